// File: rtl/calc_pkg.sv
// Shared calculator constants, widths and the converter FSM encoding.
// Imported by the arithmetic units and the BCD display path.
package calc_pkg;

  localparam int DATA_W     = 28;
  localparam int MAG_W      = 27;
  localparam int MAX_MAG    = 99_999_999;
  localparam int NUM_DIGITS = 8;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction.
// A digit of 5 or more gets +3 before the next left shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd.sv
// Signed 28-bit binary to 8-digit BCD converter.
// Sequential double-dabble, one shift per clock.
module bin_to_bcd
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d_in,
  input  logic              ovr_in,
  input  logic              valid_in,
  output logic [BCD_W-1:0]  bcd_out,
  output logic              neg_out,
  output logic              err_out,
  output logic              valid_out,
  output logic              busy
);

  state_t state, state_nx;

  logic [MAG_W-1:0]  mag;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  acc_adj;
  logic [4:0]        cnt;
  logic              neg_r;
  logic              err_r;
  logic [DATA_W-1:0] abs_val;
  logic              accept;

  // -2^27 has no 27-bit magnitude; its 28-bit abs exceeds the limit
  assign abs_val = d_in[DATA_W-1] ? (~d_in + 1'b1) : d_in;
  assign accept  = !ovr_in && (abs_val <= MAX_MAG[DATA_W-1:0]);
  assign busy    = (state != IDLE);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_add3 u_add3 (
      .digit (acc[4*i +: 4]),
      .adj   (acc_adj[4*i +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (valid_in) state_nx = accept ? SHIFT : DONE;
      SHIFT: if (cnt == 5'd1) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag       <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_r     <= 1'b0;
      err_r     <= 1'b0;
      bcd_out   <= '0;
      neg_out   <= 1'b0;
      err_out   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_in && accept) begin
            mag   <= abs_val[MAG_W-1:0];
            neg_r <= d_in[DATA_W-1];
            err_r <= 1'b0;
            acc   <= '0;
            cnt   <= 5'(MAG_W);
          end else if (valid_in) begin
            neg_r <= 1'b0;
            err_r <= 1'b1;
            acc   <= {NUM_DIGITS{BLANK_DIGIT}};
          end
        end
        SHIFT: begin
          acc <= {acc_adj[BCD_W-2:0], mag[MAG_W-1]};
          mag <= {mag[MAG_W-2:0], 1'b0};
          cnt <= cnt - 5'd1;
        end
        DONE: begin
          valid_out <= 1'b1;
          bcd_out   <= acc;
          neg_out   <= neg_r;
          err_out   <= err_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low (ports clk, rst).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 d_in  input  28  signed two's-complement result from the arithmetic unit.
REQ-005 ovr_in  input  1  overflow flag accompanying d_in (1 = magnitude beyond 99,999,999).
REQ-006 valid_in  input  1  d_in/ovr_in qualifier; a conversion request is sampled on a rising edge.
REQ-007 bcd_out  output  32  eight BCD digits, digit 7 (MSD) in [31:28], digit 0 in [3:0].
REQ-008 neg_out  output  1  sign of the converted value (1 = negative).
REQ-009 err_out  output  1  1 = overflow or out-of-range input; bcd_out holds the blank pattern.
REQ-010 valid_out  output  1  one-cycle pulse; bcd_out/neg_out/err_out are valid from this pulse until the next pulse.
REQ-011 busy  output  1  1 while a conversion is in progress; new requests are ignored.

Function
REQ-012 FSM states are IDLE, SHIFT and DONE, and the block SHALL start in IDLE.
REQ-013 In IDLE with valid_in=1 and ovr_in=0 and |d_in| <= 99,999,999: capture the 27-bit magnitude |d_in| and neg=d_in[27], clear the 32-bit BCD accumulator, load the iteration counter with 27, and go to SHIFT.
REQ-014 In IDLE with valid_in=1 and either ovr_in=1 or |d_in| > 99,999,999 (including d_in = -2^27): go to DONE with err=1, neg=0 and bcd = 0xFFFF_FFFF.
REQ-015 In SHIFT, each clock: every accumulator digit >= 5 gets +3, then {accumulator, magnitude} shifts left by 1 and the counter decrements; after the 27th shift, go to DONE.
REQ-016 In DONE, for exactly one cycle: drive valid_out=1, update the bcd_out/neg_out/err_out registers, then return to IDLE.
REQ-017 Latency: a valid request sampled at edge E0 yields valid_out high in the cycle after edge E0+28 for a conversion, and in the cycle after edge E0+1 for an error.
REQ-018 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-019 valid_in is ignored while busy=1, and no queuing of requests occurs.
REQ-020 A request whose valid_in is high on the same edge that DONE returns to IDLE is not accepted; it is accepted only when sampled in IDLE.
REQ-021 Zero input SHALL produce neg_out=0 and bcd_out=0x0000_0000; negative zero cannot occur.
REQ-022 Outputs bcd_out/neg_out/err_out SHALL be registered and SHALL hold their value between valid_out pulses.
REQ-023 Leading-zero suppression is not done here; it belongs to the display driver.

Reset
REQ-024 Assertion of rst at any time, including mid-SHIFT, SHALL force IDLE and clear the counter and accumulator, and no valid_out SHALL follow for the aborted request.
REQ-025 Reset values: bcd_out=0, neg_out=0, err_out=0, valid_out=0, busy=0.

Structure
REQ-026 Package calc_pkg SHALL hold DATA_W=28, MAG_W=27, MAX_MAG=99_999_999, NUM_DIGITS=8, BLANK_DIGIT=4'hF and the FSM state encoding, shared with the arithmetic units.
REQ-027 One sub-module, bcd_add3 (4-bit in, 4-bit out, adds 3 when in >= 5), SHALL be instantiated NUM_DIGITS times.
REQ-028 Estimated RTL size is 150-250 lines total.

Verification
REQ-029 d_in=0, valid_in pulse -> after 28 cycles valid_out=1, bcd_out=0x0000_0000, neg_out=0, err_out=0.
REQ-030 d_in=12,345,678 -> bcd_out=0x1234_5678, neg_out=0; d_in=-99,999,999 -> bcd_out=0x9999_9999, neg_out=1.
REQ-031 valid_in with ovr_in=1 (d_in=0xFFF_FFFF) -> valid_out after 1 cycle, err_out=1, bcd_out=0xFFFF_FFFF; d_in=-2^27 with ovr_in=0 -> same response.
REQ-032 Second valid_in with d_in=5 at cycle 10 of a conversion of 42 -> single valid_out, bcd_out=0x0000_0042; then a request for 5 in IDLE -> 0x0000_0005.
REQ-033 Assert rst at cycle 15 of a conversion of 777 -> all outputs at reset values, no valid_out; the next request for 777 -> 0x0000_0777.
REQ-034 Random sweep over [-99,999,999, 99,999,999], back-to-back requests -> every result matches the reference model, with latency exactly 28 cycles.
